// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back, operand-read, debug and counter signals of wb_regfile
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              reg_write_exwb;
    logic [4:0]        rd_exwb;
    logic [DATA_W-1:0] alu_result_exwb;
    logic [4:0]        rs1_id;
    logic [4:0]        rs2_id;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [CNT_W-1:0]  wb_count;

    // Pipeline side: drives the write request and read indices
    modport master (
        output reg_write_exwb, rd_exwb, alu_result_exwb, rs1_id, rs2_id, dbg_addr,
        input  read_data1, read_data2, dbg_data, wb_count
    );

    // Register file side
    modport slave (
        input  reg_write_exwb, rd_exwb, alu_result_exwb, rs1_id, rs2_id, dbg_addr,
        output read_data1, read_data2, dbg_data, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and 32-entry register file; optional macro WB_REGFILE_BYPASS_EN adds write-through bypass on the operand reads
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    logic [DATA_W-1:0] regs [0:31];
    logic [CNT_W-1:0]  wb_count_q;
    logic              commit;

    // A write only counts as a commit when it targets x1..x31; reset gates it so
    // nothing (not even the bypass path) leaks a value while reset is held.
    assign commit = reset && bus.reg_write_exwb && (bus.rd_exwb != 5'd0);

    function automatic logic [DATA_W-1:0] stored(input logic [4:0] idx);
        stored = (idx == 5'd0) ? '0 : regs[idx];
    endfunction

    // Register storage: async clear, one commit per cycle, x0 never written
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.rd_exwb] <= bus.alu_result_exwb;
        end
    end

    // Committed-write counter, wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_count_q <= '0;
        end else if (commit) begin
            wb_count_q <= wb_count_q + CNT_W'(1);
        end
    end

    // Decode-stage operand reads, with same-cycle forwarding when enabled
    always_comb begin
        bus.read_data1 = stored(bus.rs1_id);
        bus.read_data2 = stored(bus.rs2_id);
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (bus.rd_exwb == bus.rs1_id)) begin
            bus.read_data1 = bus.alu_result_exwb;
        end
        if (commit && (bus.rd_exwb == bus.rs2_id)) begin
            bus.read_data2 = bus.alu_result_exwb;
        end
`endif
    end

    // Debug port always shows the architectural (committed) value
    assign bus.dbg_data = stored(bus.dbg_addr);
    assign bus.wb_count = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    wb_regfile_if #(.DATA_W(32), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    wb_regfile #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic commit_main(input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        bus.reg_write_exwb  = 1'b1;
        bus.rd_exwb         = rd;
        bus.alu_result_exwb = d;
        @(posedge clk);
        #1;
        bus.reg_write_exwb  = 1'b0;
    endtask

    task automatic commit_w4(input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        bus4.reg_write_exwb  = 1'b1;
        bus4.rd_exwb         = rd;
        bus4.alu_result_exwb = d;
        @(posedge clk);
        #1;
        bus4.reg_write_exwb  = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        bus.reg_write_exwb   = 1'b1;
        bus.rd_exwb          = 5'd5;
        bus.alu_result_exwb  = 32'hDEADBEEF;
        bus.rs1_id           = 5'd5;
        bus.rs2_id           = 5'd0;
        bus.dbg_addr         = 5'd5;
        bus4.reg_write_exwb  = 1'b0;
        bus4.rd_exwb         = 5'd0;
        bus4.alu_result_exwb = 32'h0;
        bus4.rs1_id          = 5'd0;
        bus4.rs2_id          = 5'd0;
        bus4.dbg_addr        = 5'd9;

        // Writes presented while reset is held are dropped
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd1", bus.read_data1, 32'h0);
        check("rst_cnt", bus.wb_count, 32'h0);
        @(negedge clk);
        bus.reg_write_exwb = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_x5", bus.read_data1, 32'h0);
        check("rel_dbg_x5", bus.dbg_data, 32'h0);
        check("rel_cnt", bus.wb_count, 32'h0);

        // Basic commits to x7
        bus.rs1_id = 5'd7;
        commit_main(5'd7, 32'h12345678);
        check("x7_a", bus.read_data1, 32'h12345678);
        check("cnt_1", bus.wb_count, 32'd1);
        commit_main(5'd7, 32'hFFFFFFFF);
        check("x7_b", bus.read_data1, 32'hFFFFFFFF);
        check("cnt_2", bus.wb_count, 32'd2);

        // x0 stays zero and does not count
        bus.rs1_id = 5'd0;
        bus.rs2_id = 5'd0;
        commit_main(5'd0, 32'hAAAA5555);
        check("x0_rd1", bus.read_data1, 32'h0);
        check("x0_rd2", bus.read_data2, 32'h0);
        check("x0_cnt", bus.wb_count, 32'd2);

        // Same-cycle write and read of x3
        commit_main(5'd3, 32'h00000001);
        check("cnt_3", bus.wb_count, 32'd3);
        @(negedge clk);
        bus.rs1_id          = 5'd3;
        bus.rs2_id          = 5'd3;
        bus.dbg_addr        = 5'd3;
        bus.reg_write_exwb  = 1'b1;
        bus.rd_exwb         = 5'd3;
        bus.alu_result_exwb = 32'hCAFEF00D;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("byp_rd1_pre", bus.read_data1, 32'hCAFEF00D);
        check("byp_rd2_pre", bus.read_data2, 32'hCAFEF00D);
`else
        check("nob_rd1_pre", bus.read_data1, 32'h00000001);
        check("nob_rd2_pre", bus.read_data2, 32'h00000001);
`endif
        check("dbg_pre", bus.dbg_data, 32'h00000001);
        @(posedge clk);
        #1;
        bus.reg_write_exwb = 1'b0;
        check("x3_rd1_post", bus.read_data1, 32'hCAFEF00D);
        check("x3_rd2_post", bus.read_data2, 32'hCAFEF00D);
        check("x3_dbg_post", bus.dbg_data, 32'hCAFEF00D);
        check("cnt_4", bus.wb_count, 32'd4);

        // Fill x1..x31 with their own index
        for (int i = 1; i < 32; i++) begin
            commit_main(5'(i), 32'(i));
        end
        bus.rs1_id   = 5'd31;
        bus.rs2_id   = 5'd17;
        bus.dbg_addr = 5'd9;
        #1;
        check("fill_x31", bus.read_data1, 32'd31);
        check("fill_x17", bus.read_data2, 32'd17);
        check("fill_x9", bus.dbg_data, 32'd9);
        check("fill_cnt", bus.wb_count, 32'd35);

        // Asynchronous reset between edges, held across the next edge
        @(negedge clk);
        bus.reg_write_exwb  = 1'b1;
        bus.rd_exwb         = 5'd12;
        bus.alu_result_exwb = 32'h00000055;
        bus.rs2_id          = 5'd12;
        #1;
        check("pre_rst_x31", bus.read_data1, 32'd31);
        #1;
        reset = 1'b0;
        #1;
        check("arst_x31", bus.read_data1, 32'h0);
        check("arst_x12", bus.read_data2, 32'h0);
        check("arst_dbg", bus.dbg_data, 32'h0);
        check("arst_cnt", bus.wb_count, 32'h0);
        @(posedge clk);
        #1;
        check("arst_edge_x12", bus.read_data2, 32'h0);
        @(negedge clk);
        bus.reg_write_exwb = 1'b0;
        reset = 1'b1;
        #1;
        check("post_rst_x12", bus.read_data2, 32'h0);
        check("post_rst_cnt", bus.wb_count, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr = 5'(i);
            #1;
            check($sformatf("clr_x%0d", i), bus.dbg_data, 32'h0);
        end

        // Counter wrap on the 4-bit counter instance
        for (int i = 0; i < 16; i++) begin
            commit_w4(5'd9, 32'(i + 1));
            if (i == 14) check("w4_cnt15", 32'(bus4.wb_count), 32'd15);
        end
        check("w4_wrap", 32'(bus4.wb_count), 32'd0);
        check("w4_x9_16", bus4.dbg_data, 32'd16);
        commit_w4(5'd9, 32'h0000900D);
        check("w4_cnt_after", 32'(bus4.wb_count), 32'd1);
        check("w4_x9_final", bus4.dbg_data, 32'h0000900D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
